// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Instruction sequencer for the 16-bit CPU. An instruction is captured from
// din[8:0] when run is seen in IDLE. It is then stepped through T1..T3. The
// unit drives the bus multiplexer selects, the register-file load enables,
// the A/G enables and the ALU operation.
//
// Ports
//   clk     in   1   system clock, rising edge active
//   reset   in   1   asynchronous, active-high; forces IDLE and clears ir
//   run     in   1   start request, only looked at in IDLE
//   din     in  16   instruction source in IDLE (low 9 bits); mvi immediate
//   ir      out  9   instruction register contents
//   r_out   out  3   register select to the bus multiplexer
//   din_en  out  1   bus takes din
//   gout    out  1   bus takes G
//   r_in    out  8   one-hot load enable for r0..r7
//   a_in    out  1   load A from the bus
//   g_in    out  1   load G with the ALU result
//   alu_op  out  2   00 add, 01 sub, 10 and; 00 whenever g_in is low
//   done    out  1   high during the last step of an instruction
// ---------------------------------------------------------------------------
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] din,
    output logic [8:0]  ir,
    output logic [2:0]  r_out,
    output logic        din_en,
    output logic        gout,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic [1:0]  alu_op,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    state_t state;
    state_t next_state;

    logic [2:0] opcode;
    logic [2:0] reg_x;
    logic [2:0] reg_y;
    logic [7:0] x_onehot;
    logic       is_alu;

    // The immediate path for mvi goes straight to the bus multiplexer.
    // Only the low nine bits are needed here as the instruction.
    logic unused_din_high;
    assign unused_din_high = &{1'b0, din[15:9]};

    // Field decode of the captured instruction.
    assign opcode   = ir[8:6];
    assign reg_x    = ir[5:3];
    assign reg_y    = ir[2:0];
    assign x_onehot = 8'b0000_0001 << reg_x;
    assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

    // State register. Reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The instruction register is written only when leaving IDLE. It then
    // holds steady while din is reused for immediates or changes freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 9'd0;
        end else if ((state == IDLE) && run) begin
            ir <= din[8:0];
        end
    end

    // Next-state logic. Moves and reserved opcodes finish in T1. ALU
    // operations need T2 to load G and T3 to write the result back.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (run) begin
                    next_state = T1;
                end
            end
            T1: begin
                if (is_alu) begin
                    next_state = T2;
                end else begin
                    next_state = IDLE;
                end
            end
            T2: begin
                next_state = T3;
            end
            T3: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. Outputs depend only on the state and ir. Everything
    // idles at zero, so din_en/gout exclusivity and the one-hot r_in follow
    // from each step asserting at most one bus source and one destination.
    always_comb begin
        r_out  = 3'd0;
        din_en = 1'b0;
        gout   = 1'b0;
        r_in   = 8'd0;
        a_in   = 1'b0;
        g_in   = 1'b0;
        alu_op = ALU_ADD;
        done   = 1'b0;
        case (state)
            IDLE: begin
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        r_out = reg_y;
                        r_in  = x_onehot;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        din_en = 1'b1;
                        r_in   = x_onehot;
                        done   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        r_out = reg_x;
                        a_in  = 1'b1;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_alu) begin
                    r_out = reg_y;
                    g_in  = 1'b1;
                    case (opcode)
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_AND:  alu_op = ALU_AND;
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            T3: begin
                if (is_alu) begin
                    gout = 1'b1;
                    r_in = x_onehot;
                    done = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Table of per-cycle vectors (reset, run, din, expected outputs). Each vector
// is driven on the falling edge. Its expected output bundle is queued at that
// time and popped shortly afterwards for comparison. Hand-written sequences
// then cover done pulse counting and reset during T3.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic [8:0]  ir;
    logic [2:0]  r_out;
    logic        din_en;
    logic        gout;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic [1:0]  alu_op;
    logic        done;

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .din    (din),
        .ir     (ir),
        .r_out  (r_out),
        .din_en (din_en),
        .gout   (gout),
        .r_in   (r_in),
        .a_in   (a_in),
        .g_in   (g_in),
        .alu_op (alu_op),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        run;
        logic [15:0] din;
        logic [26:0] expect_bits;
    } vec_t;

    vec_t        vecs[$];
    logic [26:0] scoreboard[$];

    logic [26:0] actual_bits;
    assign actual_bits = {ir, r_out, din_en, gout, r_in, a_in, g_in, alu_op, done};

    // Pack an expected output bundle in the same order as actual_bits.
    function automatic logic [26:0] mk(input logic [8:0] e_ir, input logic [2:0] e_rout,
                                       input logic e_dinen, input logic e_gout,
                                       input logic [7:0] e_rin, input logic e_ain,
                                       input logic e_gin, input logic [1:0] e_alu,
                                       input logic e_done);
        return {e_ir, e_rout, e_dinen, e_gout, e_rin, e_ain, e_gin, e_alu, e_done};
    endfunction

    function automatic logic [26:0] idle_out(input logic [8:0] e_ir);
        return mk(e_ir, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    endfunction

    task automatic addVec(input string name, input logic rst, input logic r,
                          input logic [15:0] d, input logic [26:0] e);
        vec_t v;
        v.name        = name;
        v.rst         = rst;
        v.run         = r;
        v.din         = d;
        v.expect_bits = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset = v.rst;
        run   = v.run;
        din   = v.din;
        scoreboard.push_back(v.expect_bits);
    endtask

    task automatic checkOutput(input string name);
        logic [26:0] e;
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard empty", name);
        end else begin
            e = scoreboard.pop_front();
            checks++;
            if (actual_bits !== e) begin
                failures++;
                $display("[TB] FAIL %s actual=%07h required=%07h", name, actual_bits, e);
            end
        end
        checks++;
        if ((din_en && gout) || !$onehot0(r_in) || (!g_in && alu_op != 2'b00)) begin
            failures++;
            $display("[TB] FAIL %s_invariant din_en=%b gout=%b r_in=%02h g_in=%b alu_op=%b required exclusive/onehot0/alu0",
                     name, din_en, gout, r_in, g_in, alu_op);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        int done_count;
        int done_at;
        int stray;

        reset = 1'b1;
        run   = 1'b0;
        din   = 16'h0000;

        // Expected values: field layout opcode[8:6] X[5:3] Y[2:0].
        addVec("reset",        1, 0, 16'h0000, idle_out(9'h000));
        // mv r5,r3
        addVec("mv_idle",      0, 1, 16'h002B, idle_out(9'h000));
        addVec("mv_t1",        0, 0, 16'h0000, mk(9'h02B, 3'd3, 0, 0, 8'h20, 0, 0, 2'b00, 1));
        addVec("mv_back_idle", 0, 0, 16'h0000, idle_out(9'h02B));
        // mvi r1, 0x1234
        addVec("mvi_idle",     0, 1, 16'h0048, idle_out(9'h02B));
        addVec("mvi_t1",       0, 0, 16'h1234, mk(9'h048, 3'd0, 1, 0, 8'h02, 0, 0, 2'b00, 1));
        addVec("mvi_back",     0, 0, 16'h1234, idle_out(9'h048));
        // sub r0,r7
        addVec("sub_idle",     0, 1, 16'h00C7, idle_out(9'h048));
        addVec("sub_t1",       0, 0, 16'h0000, mk(9'h0C7, 3'd0, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        addVec("sub_t2",       0, 0, 16'h0000, mk(9'h0C7, 3'd7, 0, 0, 8'h00, 0, 1, 2'b01, 0));
        addVec("sub_t3",       0, 0, 16'h0000, mk(9'h0C7, 3'd0, 0, 1, 8'h01, 0, 0, 2'b00, 1));
        addVec("sub_back",     0, 0, 16'h0000, idle_out(9'h0C7));
        // add r4,r4
        addVec("add44_idle",   0, 1, 16'h00A4, idle_out(9'h0C7));
        addVec("add44_t1",     0, 0, 16'h0000, mk(9'h0A4, 3'd4, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        addVec("add44_t2",     0, 0, 16'h0000, mk(9'h0A4, 3'd4, 0, 0, 8'h00, 0, 1, 2'b00, 0));
        addVec("add44_t3",     0, 0, 16'h0000, mk(9'h0A4, 3'd0, 0, 1, 8'h10, 0, 0, 2'b00, 1));
        addVec("add44_back",   0, 0, 16'h0000, idle_out(9'h0A4));
        // and r1,r2 then mv r3,r2 then reserved, run held high; din churns mid-op
        addVec("and_idle",     0, 1, 16'h010A, idle_out(9'h0A4));
        addVec("and_t1",       0, 1, 16'h010A, mk(9'h10A, 3'd1, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        addVec("and_t2",       0, 1, 16'h011D, mk(9'h10A, 3'd2, 0, 0, 8'h00, 0, 1, 2'b10, 0));
        addVec("and_t3",       0, 1, 16'h00D1, mk(9'h10A, 3'd0, 0, 1, 8'h02, 0, 0, 2'b00, 1));
        addVec("mv32_idle",    0, 1, 16'h001A, idle_out(9'h10A));
        addVec("mv32_t1",      0, 1, 16'h001A, mk(9'h01A, 3'd2, 0, 0, 8'h08, 0, 0, 2'b00, 1));
        addVec("rsv_idle",     0, 1, 16'h01FF, idle_out(9'h01A));
        addVec("rsv_t1",       0, 0, 16'h0000, mk(9'h1FF, 3'd0, 0, 0, 8'h00, 0, 0, 2'b00, 1));
        addVec("rsv_back",     0, 0, 16'h0000, idle_out(9'h1FF));
        addVec("rsv_stay",     0, 0, 16'h0000, idle_out(9'h1FF));
        // add r4,r2 (0x0A2) interrupted by reset in T2
        addVec("add42_idle",   0, 1, 16'h00A2, idle_out(9'h1FF));
        addVec("add42_t1",     0, 0, 16'h0000, mk(9'h0A2, 3'd4, 0, 0, 8'h00, 1, 0, 2'b00, 0));
        addVec("add42_rst_t2", 1, 0, 16'h0000, idle_out(9'h000));
        // first edge after release samples run: mvi r1
        addVec("rel_idle",     0, 1, 16'h004F, idle_out(9'h000));
        addVec("rel_mvi_t1",   0, 0, 16'h0000, mk(9'h04F, 3'd0, 1, 0, 8'h02, 0, 0, 2'b00, 1));
        addVec("rel_back",     0, 0, 16'h0000, idle_out(9'h04F));
        addVec("rel_stay",     0, 0, 16'h0000, idle_out(9'h04F));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name);
        end

        // Single and r2,r3: done must appear exactly once, three cycles after issue.
        @(negedge clk);
        run = 1'b1;
        din = 16'h0113;
        done_count = 0;
        done_at    = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            run = 1'b0;
            din = 16'hFFFF;
            #1;
            if (done) begin
                done_count++;
                if (done_at < 0) done_at = i;
            end
        end
        checkValue("and_done_count", done_count, 1);
        checkValue("and_done_cycle", done_at, 3);

        // Reset asserted in T3 of sub r6,r1: writeback disappears at once
        // and nothing is written afterwards.
        @(negedge clk);
        run = 1'b1;
        din = 16'h00F1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkValue("t3_gout_before_reset", int'(gout), 1);
        checkValue("t3_rin_before_reset", int'(r_in), 8'h40);
        #2;
        reset = 1'b1;
        #1;
        checkValue("t3_rin_after_reset", int'(r_in), 0);
        checkValue("t3_ir_after_reset", int'(ir), 0);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = (i < 1);
            #1;
            if (r_in != 8'h00 || gout || done) stray++;
        end
        checkValue("post_reset_stray_pulses", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
